// File: rtl/btpipe_out_buffer.sv
// btpipe_out_buffer: block-throttled FIFO feeding an okBTPipeOut endpoint.
// Words from the producer are stored in a dual-port RAM. pipe_out_ready is
// raised only while a complete block is buffered that no burst has claimed yet.
// Optional build macro: BTPIPE_OUT_STATS_EN enables the overflow/underflow
// counters and clear_counts. Without it the counters are tied to zero.
module btpipe_out_buffer #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    output logic                  full,
    input  logic                  pipe_out_read,
    output logic [31:0]           pipe_out_data,
    output logic                  pipe_out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           overflow_count,
    output logic [15:0]           underflow_count,
    input  logic                  clear_counts
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned REM_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW:0]   BLOCK_L = (LW + 1)'(BLOCK_WORDS);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release waits two edges.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Two-stage release synchroniser for the asynchronous reset input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q,  level_d;
    logic [31:0]           data_q,   data_d;
    logic                  ready_q,  ready_d;
    state_t                state_q,  state_d;
    logic [REM_W-1:0]      remain_q, remain_d;
    logic [LW:0]           claimed_d;

    logic full_w;
    logic wr_ok;
    logic rd_ok;
    logic rd_under;

    assign full_w   = (level_q == DEPTH_L);
    assign wr_ok    = wr_en && !full_w;
    assign rd_ok    = pipe_out_read && (level_q != '0);
    assign rd_under = pipe_out_read && (level_q == '0);

    // RAM write port; the array itself carries no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer, level and output-data next-state logic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = data_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end

        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            data_d   = mem_q[rd_ptr_q];
        end else if (rd_under) begin
            data_d   = '0;
        end

        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Burst tracking and registered ready evaluation on next-state values.
    // remain holds (unread words of the claimed block) - 1, so the read that
    // opens a burst has already consumed one word and loads BLOCK_WORDS-2;
    // claimed = remain+1 then equals the words still owed to the host.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;

        if (pipe_out_read) begin
            case (state_q)
                IDLE: begin
                    if (BLOCK_WORDS > 1) begin
                        state_d  = BURST;
                        remain_d = REM_W'(BLOCK_WORDS - 2);
                    end
                end
                BURST: begin
                    if (remain_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remain_d = remain_q - REM_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end

        claimed_d = '0;
        if (state_d == BURST) begin
            claimed_d = (LW + 1)'(remain_d) + (LW + 1)'(1);
        end

        ready_d = ({1'b0, level_d} >= (claimed_d + BLOCK_L));
    end

    // Datapath and FSM registers; reset discards all buffered words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            state_q  <= IDLE;
            remain_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    assign full           = full_w;
    assign level          = level_q;
    assign pipe_out_data  = data_q;
    assign pipe_out_ready = ready_q;

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
`ifdef BTPIPE_OUT_STATS_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] unf_q, unf_d;

    // Saturating counters; clear wins over a same-cycle increment
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_counts) begin
            ovf_d = '0;
            unf_d = '0;
        end else begin
            if (wr_en && full_w && (ovf_q != '1)) begin
                ovf_d = ovf_q + 16'd1;
            end
            if (rd_under && (unf_q != '1)) begin
                unf_d = unf_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_count  = ovf_q;
    assign underflow_count = unf_q;
`else
    logic unused_clear_counts;
    assign unused_clear_counts = clear_counts;

    assign overflow_count  = 16'h0;
    assign underflow_count = 16'h0;
`endif

endmodule

// File: tb/tb_btpipe_out_buffer.sv
// Testbench for btpipe_out_buffer with DEPTH_LOG2=4, BLOCK_WORDS=4.
// Expected values come from vector tables, hand sequences and a queue-based
// model that tracks buffered words and words owed to the current burst.
module tb_btpipe_out_buffer;

    localparam int unsigned DL2   = 4;
    localparam int unsigned BLK   = 4;
    localparam int unsigned DEPTH = 1 << DL2;

`ifdef BTPIPE_OUT_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          full;
    logic          pipe_out_read = 1'b0;
    logic [31:0]   pipe_out_data;
    logic          pipe_out_ready;
    logic [DL2:0]  level;
    logic [15:0]   overflow_count;
    logic [15:0]   underflow_count;
    logic          clear_counts = 1'b0;

    btpipe_out_buffer #(
        .DEPTH_LOG2  (DL2),
        .BLOCK_WORDS (BLK)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .pipe_out_read   (pipe_out_read),
        .pipe_out_data   (pipe_out_data),
        .pipe_out_ready  (pipe_out_ready),
        .level           (level),
        .overflow_count  (overflow_count),
        .underflow_count (underflow_count),
        .clear_counts    (clear_counts)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_data;
    int          m_owed;
    int          m_ovf;
    int          m_unf;
    bit          m_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data  = '0;
        m_owed  = 0;
        m_ovf   = 0;
        m_unf   = 0;
        m_ready = 1'b0;
    endtask

    // One clock edge worth of buffer behaviour, from pre-edge state
    task automatic model_step(input logic w, input logic [31:0] d, input logic r, input logic c);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (r) begin
            if (mq.size() != 0) begin
                m_data = mq.pop_front();
            end else begin
                m_data = '0;
                if (!c && m_unf < 65535) m_unf++;
            end
            // a burst hands out BLK words; the first read opens it
            if (m_owed == 0) m_owed = BLK - 1;
            else m_owed--;
        end
        if (w) begin
            if (!was_full) mq.push_back(d);
            else if (!c && m_ovf < 65535) m_ovf++;
        end
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        m_ready = (int'(mq.size()) - m_owed) >= int'(BLK);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".full"},  32'(full),  32'(mq.size() == DEPTH));
        chk({tag, ".ready"}, 32'(pipe_out_ready), 32'(m_ready));
        chk({tag, ".data"},  pipe_out_data, m_data);
        chk({tag, ".ovf"},   32'(overflow_count),  STATS_EN ? 32'(m_ovf) : 32'd0);
        chk({tag, ".unf"},   32'(underflow_count), STATS_EN ? 32'(m_unf) : 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge pass, then check
    task automatic step(input string tag, input logic w, input logic [31:0] d,
                        input logic r, input logic c);
        wr_en         = w;
        wr_data       = d;
        pipe_out_read = r;
        clear_counts  = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        wr_en         = 1'b0;
        pipe_out_read = 1'b0;
        clear_counts  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".rst_now"});
        #20;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all({tag, ".rst_rel"});
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rd;
        int          lvl;
        logic        rdy;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Fill 8 words then drain them; ready tracks unclaimed complete blocks
        tbl[0]  = '{1'b1, 32'd1, 1'b0, 1, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 32'd2, 1'b0, 2, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 32'd3, 1'b0, 3, 1'b0, 32'd0};
        tbl[3]  = '{1'b1, 32'd4, 1'b0, 4, 1'b1, 32'd0};
        tbl[4]  = '{1'b1, 32'd5, 1'b0, 5, 1'b1, 32'd0};
        tbl[5]  = '{1'b1, 32'd6, 1'b0, 6, 1'b1, 32'd0};
        tbl[6]  = '{1'b1, 32'd7, 1'b0, 7, 1'b1, 32'd0};
        tbl[7]  = '{1'b1, 32'd8, 1'b0, 8, 1'b1, 32'd0};
        tbl[8]  = '{1'b0, 32'd0, 1'b1, 7, 1'b1, 32'd1};
        tbl[9]  = '{1'b0, 32'd0, 1'b1, 6, 1'b1, 32'd2};
        tbl[10] = '{1'b0, 32'd0, 1'b1, 5, 1'b1, 32'd3};
        tbl[11] = '{1'b0, 32'd0, 1'b1, 4, 1'b1, 32'd4};
        tbl[12] = '{1'b0, 32'd0, 1'b1, 3, 1'b0, 32'd5};
        tbl[13] = '{1'b0, 32'd0, 1'b1, 2, 1'b0, 32'd6};
        tbl[14] = '{1'b0, 32'd0, 1'b1, 1, 1'b0, 32'd7};
        tbl[15] = '{1'b0, 32'd0, 1'b1, 0, 1'b0, 32'd8};

        model_reset();
        do_reset("init");

        for (int i = 0; i < 16; i++) begin
            step("tbl", tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
            chk($sformatf("tbl[%0d].level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl[%0d].ready", i), 32'(pipe_out_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl[%0d].data", i),  pipe_out_data, tbl[i].dat);
        end

        // Fill to full, overflow by two, then drain in order
        do_reset("ovf");
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        chk("full_at_16", 32'(full), 32'd1);
        step("ovf1", 1'b1, 32'hDEAD, 1'b0, 1'b0);
        step("ovf2", 1'b1, 32'hBEEF, 1'b0, 1'b0);
        chk("ovf_count", 32'(overflow_count), STATS_EN ? 32'd2 : 32'd0);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("drain[%0d]", i), pipe_out_data, 32'h1000 + 32'(i));
        end
        chk("drain_empty", 32'(level), 32'd0);

        // Underflow reads return zero; clear zeroes the counters
        do_reset("unf");
        step("unf_w", 1'b1, 32'hABCD, 1'b0, 1'b0);
        step("unf_r", 1'b0, '0, 1'b1, 1'b0);
        chk("unf_valid_data", pipe_out_data, 32'hABCD);
        for (int i = 0; i < 3; i++) begin
            step("unf", 1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("unf_data[%0d]", i), pipe_out_data, 32'h0);
        end
        chk("unf_count", 32'(underflow_count), STATS_EN ? 32'd3 : 32'd0);
        step("clr", 1'b0, '0, 1'b0, 1'b1);
        chk("unf_cleared", 32'(underflow_count), 32'd0);

        // Simultaneous read and write at level 5 across pointer wrap
        do_reset("sim");
        for (int i = 0; i < 5; i++) step("sim_fill", 1'b1, 32'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("sim_rw", 1'b1, 32'(100 + i), 1'b1, 1'b0);
            chk($sformatf("sim_level[%0d]", i), 32'(level), 32'd5);
            chk($sformatf("sim_data[%0d]", i), pipe_out_data,
                (i < 5) ? 32'(i + 1) : 32'(100 + i - 5));
        end

        // Reset mid-burst discards data; a fresh fill raises ready again
        do_reset("mid");
        for (int i = 0; i < 4; i++) step("mid_fill", 1'b1, 32'(50 + i), 1'b0, 1'b0);
        chk("mid_ready", 32'(pipe_out_ready), 32'd1);
        step("mid_rd", 1'b0, '0, 1'b1, 1'b0);
        step("mid_rd", 1'b0, '0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ready", 32'(pipe_out_ready), 32'd0);
        chk("mid_rst_data",  pipe_out_data, 32'd0);
        chk("mid_rst_full",  32'(full), 32'd0);
        do_reset("mid2");
        for (int i = 0; i < 3; i++) step("refill", 1'b1, 32'(70 + i), 1'b0, 1'b0);
        chk("refill3_ready", 32'(pipe_out_ready), 32'd0);
        step("refill", 1'b1, 32'd73, 1'b0, 1'b0);
        chk("refill4_ready", 32'(pipe_out_ready), 32'd1);
        chk("refill4_level", 32'(level), 32'd4);
        step("refill_rd", 1'b0, '0, 1'b1, 1'b0);
        chk("refill_first", pipe_out_data, 32'd70);

        // Randomised traffic against the model, write-heavy then read-heavy
        do_reset("rnd");
        for (int i = 0; i < 900; i++) begin
            int unsigned wp;
            logic w;
            logic r;
            logic c;
            wp = (i < 300) ? 70 : ((i < 600) ? 35 : 50);
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < (100 - wp));
            c  = ($urandom_range(0, 79) == 0);
            step("rnd", w, $urandom, r, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
